// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths, address/word types and the x0 constant for the
//               multi-ported register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int RF_W = 32;
  localparam int RF_A = 5;

  typedef logic [RF_A-1:0] reg_addr_t;
  typedef logic [RF_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : In-flight write tracker. One pending bit per register is set
//               at issue and cleared at writeback (set wins on a tie). Busy
//               flags per read port are masked by the writeback bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
  parameter int A  = 5,
  parameter int NR = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NR*A-1:0] rd_addr,
  output logic [NR-1:0] rd_busy,
  input  logic          wr_en,
  input  logic [A-1:0]  wr_addr,
  input  logic          issue_valid,
  input  logic [A-1:0]  issue_addr,
  output logic          any_busy
);

  localparam int c_depth = 1 << A;

  logic [c_depth-1:0] r_pending;
  logic [c_depth-1:0] w_pending_next;

  // Next pending vector: clear on writeback first so a same-address issue overrides it.
  always_comb begin
    w_pending_next = r_pending;
    if (wr_en) begin
      w_pending_next[wr_addr] = 1'b0;
    end
    if (issue_valid) begin
      w_pending_next[issue_addr] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  // Pending state register; reset drops every outstanding writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_busy
    logic [A-1:0] w_addr;
    assign w_addr = rd_addr[gi*A +: A];
    // A value being written back this cycle is forwarded, so it is not a hazard.
    assign rd_busy[gi] = r_pending[w_addr] && !(wr_en && (wr_addr == w_addr));
  end

  assign any_busy = |r_pending;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : NR-read / 1-write register file with write-first forwarding,
//               x0 hardwired to zero, registered read data and an in-flight
//               write scoreboard for RAW hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
  import rf_pkg::*;
#(
  parameter int W  = RF_W,
  parameter int A  = RF_A,
  parameter int NR = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NR*A-1:0] rd_addr,
  output logic [NR*W-1:0] rd_data,
  output logic [NR-1:0]   rd_busy,
  input  logic            wr_en,
  input  logic [A-1:0]    wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            issue_valid,
  input  logic [A-1:0]    issue_addr,
  output logic            any_busy
);

  localparam int c_depth = 1 << A;

  logic [W-1:0] r_regs [c_depth];
  logic         w_wr_ok;

  // Writes to x0 are dropped here so entry 0 stays at its reset value.
  assign w_wr_ok = wr_en && (wr_addr != A'(REG_ZERO));

  // Storage array as flops so the asynchronous reset clears every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd_port
    logic [A-1:0] w_addr;
    logic [W-1:0] w_next;
    logic [W-1:0] r_data;

    assign w_addr = rd_addr[gi*A +: A];

    // Read mux: x0 is zero, a same-edge write to this address is forwarded.
    always_comb begin
      w_next = r_regs[w_addr];
      if (w_addr == A'(REG_ZERO)) begin
        w_next = '0;
      end else if (w_wr_ok && (wr_addr == w_addr)) begin
        w_next = wr_data;
      end
    end

    // Registered read data for this port.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data <= '0;
      end else begin
        r_data <= w_next;
      end
    end

    assign rd_data[gi*W +: W] = r_data;
  end

  rf_scoreboard #(
    .A  (A),
    .NR (NR)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .any_busy    (any_busy)
  );

endmodule : register_file_mp
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_mp
// Description : Self-checking bench for register_file_mp with NR = 1, 2, 3
//               instances sharing write/issue/reset stimulus. A behavioural
//               model of the architectural state is compared every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  ra [6];

  logic [4:0]  rd_addr1;
  logic [9:0]  rd_addr2;
  logic [14:0] rd_addr3;
  logic [31:0] rd_data1;
  logic [63:0] rd_data2;
  logic [95:0] rd_data3;
  logic [0:0]  busy1;
  logic [1:0]  busy2;
  logic [2:0]  busy3;
  logic        any1, any2, any3;

  logic [31:0] act_rd [6];
  logic [5:0]  act_busy;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic [31:0] exp_rd [6];

  int checks;
  int failures;
  bit cmp_on;

  assign rd_addr1 = ra[0];
  assign rd_addr2 = {ra[2], ra[1]};
  assign rd_addr3 = {ra[5], ra[4], ra[3]};

  assign act_rd[0] = rd_data1;
  assign act_rd[1] = rd_data2[31:0];
  assign act_rd[2] = rd_data2[63:32];
  assign act_rd[3] = rd_data3[31:0];
  assign act_rd[4] = rd_data3[63:32];
  assign act_rd[5] = rd_data3[95:64];
  assign act_busy  = {busy3, busy2, busy1};

  register_file_mp #(.W(32), .A(5), .NR(1)) u_dut1 (
    .clk(clk), .reset(rst), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .any_busy(any1)
  );

  register_file_mp #(.W(32), .A(5), .NR(2)) u_dut2 (
    .clk(clk), .reset(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .any_busy(any2)
  );

  register_file_mp #(.W(32), .A(5), .NR(3)) u_dut3 (
    .clk(clk), .reset(rst), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_busy(busy3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .any_busy(any3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: reset clears everything.
  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_pend = '0;
    for (int p = 0; p < 6; p++) exp_rd[p] = '0;
  endtask

  // Architectural model: one clock edge. Write lands first, reads see it.
  task automatic model_step();
    if (wr_en && wr_addr != 0) begin
      m_regs[wr_addr] = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    for (int p = 0; p < 6; p++) exp_rd[p] = (ra[p] == 0) ? 32'd0 : m_regs[ra[p]];
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    ra[0] = a0; ra[1] = a0; ra[2] = a1;
    ra[3] = a0; ra[4] = a1; ra[5] = 5'd0;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    idle_in();
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int p = 0; p < 6; p++) begin
        chk($sformatf("rd_data[%0d]", p), act_rd[p], exp_rd[p]);
        chk($sformatf("rd_busy[%0d]", p), 32'(act_busy[p]),
            32'(m_pend[ra[p]] && !(wr_en && wr_addr == ra[p])));
      end
      chk("any_busy_nr1", 32'(any1), 32'(|m_pend));
      chk("any_busy_nr2", 32'(any2), 32'(|m_pend));
      chk("any_busy_nr3", 32'(any3), 32'(|m_pend));
    end
  end

  initial begin
    checks = 0; failures = 0; cmp_on = 1'b0;
    idle_in();
    set_rd(5'd0, 5'd0);
    rst = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    cmp_on = 1'b1;
    tick();
    chk("reset_rd0", rd_data2[31:0], 32'd0);
    chk("reset_any", 32'(any2), 32'd0);

    // 1: reset mid-run, including a write in flight.
    do_write(5'd1, 32'h11);
    do_write(5'd2, 32'h22);
    issue_valid = 1'b1; issue_addr = 5'd4; tick(); idle_in();
    set_rd(5'd1, 5'd4);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    rst = 1'b1; model_reset();
    #1;
    chk("rst_hold_rd0", rd_data2[31:0], 32'd0);
    chk("rst_hold_rd1", rd_data2[63:32], 32'd0);
    chk("rst_hold_busy", 32'(busy2), 32'd0);
    chk("rst_hold_any", 32'(any2), 32'd0);
    tick();
    rst = 1'b0; idle_in();
    for (int i = 1; i < 32; i++) begin
      set_rd(5'(i), 5'(i));
      tick();
      chk("post_rst_read", rd_data2[31:0] | rd_data2[63:32], 32'd0);
    end

    // 2: fill and readback.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i * 10 + 1));
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      tick();
      chk("fill_p0", rd_data2[31:0], (i == 0) ? 32'd0 : 32'(i * 10 + 1));
      chk("fill_p1", rd_data2[63:32], (i == 31) ? 32'd0 : 32'(i == 0 ? 311 : (31 - i) * 10 + 1));
    end

    // 3: forwarding and x0 write.
    do_write(5'd5, 32'd7);
    set_rd(5'd5, 5'd5);
    do_write(5'd5, 32'd99);
    chk("fwd_p0", rd_data2[31:0], 32'd99);
    chk("fwd_p1", rd_data2[63:32], 32'd99);
    set_rd(5'd0, 5'd5);
    do_write(5'd0, 32'hDEAD);
    chk("x0_write_p0", rd_data2[31:0], 32'd0);
    chk("x0_write_p1", rd_data2[63:32], 32'd99);

    // 4: scoreboard issue then writeback.
    issue_valid = 1'b1; issue_addr = 5'd7; tick(); idle_in();
    set_rd(5'd7, 5'd7);
    #1;
    chk("sb_busy", 32'(busy2), 32'd3);
    chk("sb_any", 32'(any2), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
    #1;
    chk("sb_bypass_busy", 32'(busy2), 32'd0);
    tick(); idle_in();
    #1;
    chk("sb_wb_data", rd_data2[31:0], 32'd42);
    chk("sb_wb_busy", 32'(busy2), 32'd0);
    chk("sb_wb_any", 32'(any2), 32'd0);

    // 5: simultaneous set and clear; x0 issue.
    issue_valid = 1'b1; issue_addr = 5'd3; tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; tick(); idle_in();
    set_rd(5'd3, 5'd3);
    #1;
    chk("set_wins_busy", 32'(busy2), 32'd3);
    chk("set_wins_any", 32'(any2), 32'd1);
    do_write(5'd3, 32'h34);
    issue_valid = 1'b1; issue_addr = 5'd0; set_rd(5'd0, 5'd0); tick(); idle_in();
    #1;
    chk("x0_issue_busy", 32'(busy2), 32'd0);
    chk("x0_issue_any", 32'(any2), 32'd0);

    // 6: random traffic with occasional reset pulses.
    for (int n = 0; n < 10000; n++) begin
      for (int p = 0; p < 6; p++) ra[p] = 5'($urandom_range(0, 31));
      wr_en       = ($urandom_range(0, 1) == 1);
      wr_addr     = 5'($urandom_range(0, 31));
      wr_data     = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    idle_in();
    tick();
    cmp_on = 1'b0;
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file_mp
`default_nettype wire
